imem_loader: RTL and testbench

Hardware program loader that receives a framed byte stream from a host link (UART or debug bridge) over a valid/ready handshake. It assembles little-endian 32-bit instruction words and writes them into the instruction memory write port. It holds the core in reset until a frame completes with a valid checksum. Sits between the host byte link and the imem/cpu_single_cycle reset input.

---
 rtl/imem_loader_pkg.sv | 6 +
 rtl/imem_loader_csum.sv | 14 +
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and framing constants for the program loader.
package imem_loader_pkg;
   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int LEN_WIDTH = 16;
endpackage

// File: rtl/imem_loader_csum.sv
// imem_loader_csum: byte-wide XOR accumulator with synchronous clear and enable.
module imem_loader_csum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] d,
   output logic [7:0] q
);
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (clr) q <= '0;
      else if (en) q <= q ^ d;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses SYNC/LEN/words/CSUM byte frames into imem writes and gates the core reset.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDR_WIDTH = 8,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_waddr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rst_n,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam logic [31:0] DEPTH = 32'(1) << ADDR_WIDTH;
   state_t                state;
   logic [7:0]            len_lo;
   logic [LEN_WIDTH-1:0]  len;
   logic [LEN_WIDTH-1:0]  rem;
   logic [ADDR_WIDTH-1:0] addr;
   logic [1:0]            bidx;
   logic [23:0]           word;
   logic [7:0]            csum;
   logic                  acc;
   logic                  sync;
   assign acc  = s_valid && s_ready;
   assign sync = acc && s_data == SYNC_BYTE && (state == IDLE || state == DONE || state == ERR);
   assign len  = {s_data, len_lo};
   imem_loader_csum u_csum (
      .clk(clk),
      .rst(rst),
      .clr(sync),
      .en (acc && (state == LEN0 || state == LEN1 || state == DATA)),
      .d  (s_data),
      .q  (csum)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         s_ready    <= 1'b1;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         cpu_rst_n  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         len_lo     <= '0;
         rem        <= '0;
         addr       <= '0;
         bidx       <= '0;
         word       <= '0;
      end else begin
         s_ready <= 1'b1;
         imem_we <= 1'b0;
         if (sync) begin
            state     <= LEN0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
         end else if (acc) begin
            case (state)
               LEN0: begin
                  len_lo <= s_data;
                  state  <= LEN1;
               end
               LEN1: begin
                  rem  <= len;
                  addr <= '0;
                  bidx <= '0;
                  if ({16'h0, len} > DEPTH) begin
                     state <= ERR;
                     err   <= 1'b1;
                     busy  <= 1'b0;
                  end else state <= (len == '0) ? CSUM : DATA;
               end
               DATA: begin
                  bidx <= bidx + 1'b1;
                  word <= {s_data, word[23:8]};
                  // bytes arrive LSB first, so the 4th byte completes the word on the fly
                  if (bidx == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_wdata <= {s_data, word};
                     imem_waddr <= addr;
                     addr       <= addr + 1'b1;
                     rem        <= rem - 1'b1;
                     if (rem == LEN_WIDTH'(1)) state <= CSUM;
                  end
               end
               CSUM: begin
                  busy <= 1'b0;
                  if (s_data == csum) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     cpu_rst_n <= 1'b1;
                  end else begin
                     state <= ERR;
                     err   <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus with a scoreboard of expected imem writes.
module tb_imem_loader;
   localparam int DEPTH = 256;
   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_ready, imem_we, cpu_rst_n, busy, done, err;
   logic [7:0] imem_waddr;
   logic [31:0] imem_wdata;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   wr_t exp_q[$];
   logic [31:0] frame_words[$];
   bit pend_valid = 0;
   wr_t pend;
   logic prev_we = 1'b0;
   imem_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask
   // Monitor: every write strobe must match the head of the scoreboard, in data, address and timing.
   always @(negedge clk) begin
      if (imem_we) begin
         wr_t e;
         chk("we_not_back_to_back", 32'(prev_we), 0);
         if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(imem_waddr), 32'(e.addr));
            chk("wr_data", imem_wdata, e.data);
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      prev_we = imem_we;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   task automatic send_byte(input logic [7:0] b);
      repeat ($urandom_range(0, 2)) begin
         s_valid = 1'b0;
         s_data  = 8'($urandom_range(0, 255));
         @(negedge clk);
      end
      chk("s_ready", 32'(s_ready), 1);
      s_valid = 1'b1;
      s_data  = b;
      if (pend_valid) begin
         pend.cyc = cyc + 1;
         exp_q.push_back(pend);
         pend_valid = 0;
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask
   task automatic chk_status(input string tag, input bit b, input bit d, input bit e, input bit r);
      chk({tag, "_busy"}, 32'(busy), 32'(b));
      chk({tag, "_done"}, 32'(done), 32'(d));
      chk({tag, "_err"}, 32'(err), 32'(e));
      chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(r));
   endtask
   task automatic chk_reset();
      chk("rst_s_ready", 32'(s_ready), 1);
      chk("rst_imem_we", 32'(imem_we), 0);
      chk("rst_waddr", 32'(imem_waddr), 0);
      chk("rst_wdata", imem_wdata, 0);
      chk_status("rst", 0, 0, 0, 0);
   endtask
   // Frame-level model: words 0..n-1 land at addresses 0..n-1 unless n exceeds the depth;
   // outcome is decided by comparing the sent checksum against the XOR of length and data bytes.
   task automatic send_frame(input int n, input bit corrupt, input int noise);
      logic [7:0] cs, b;
      logic [31:0] w;
      for (int i = 0; i < noise; i++) begin
         b = 8'($urandom_range(0, 255));
         send_byte(b == 8'hA5 ? 8'h00 : b);
      end
      send_byte(8'hA5);
      chk_status("sync", 1, 0, 0, 0);
      cs = 8'(n) ^ 8'(n >> 8);
      send_byte(8'(n));
      send_byte(8'(n >> 8));
      if (n > DEPTH) begin
         chk_status("oversize", 0, 0, 1, 0);
         return;
      end
      for (int i = 0; i < n; i++) begin
         w = frame_words[i];
         for (int k = 0; k < 4; k++) begin
            b = 8'(w >> (8 * k));
            cs ^= b;
            if (k == 3) begin
               pend.addr = 8'(i);
               pend.data = w;
               pend_valid = 1;
            end
            send_byte(b);
         end
      end
      send_byte(cs ^ {7'b0, corrupt});
      chk_status(corrupt ? "bad_csum" : "good_csum", 0, !corrupt, corrupt, !corrupt);
   endtask
   task automatic rand_words(input int n);
      frame_words.delete();
      for (int i = 0; i < n; i++) frame_words.push_back($urandom);
   endtask
   initial begin
      @(negedge clk);
      chk_reset();
      rst = 1'b0;
      @(negedge clk);
      frame_words = '{32'h00a00093, 32'h01400113, 32'h002081b3};
      send_frame(3, 0, 0);
      send_frame(3, 1, 0);
      send_frame(3, 0, 3);
      send_frame(257, 0, 0);
      send_frame(0, 0, 0);
      rand_words(DEPTH);
      send_frame(DEPTH, 0, 0);
      for (int t = 0; t < 8; t++) begin
         int n;
         n = $urandom_range(0, 7);
         rand_words(n);
         send_frame(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
      frame_words = '{32'h00a00093, 32'h01400113, 32'h002081b3};
      send_frame(3, 0, 0);
      send_byte(8'hA5);
      chk_status("reload", 1, 0, 0, 0);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      rst = 1'b1;
      @(negedge clk);
      chk_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rand_words(5);
      send_frame(5, 0, 2);
      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
